// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//   Two-requester arbiter for a single-port on-chip RAM. Requester m0 (Nios
//   data master) and m1 (DCNN accelerator master) present Avalon-MM slave
//   interfaces with waitrequest/readdatavalid; the arbiter drives the RAM pins.
//
//   Grant is combinational: a request is accepted in the same cycle it is
//   presented, one beat per cycle. Read data arrives from the RAM one cycle
//   after the read beat. It is passed straight through to both requesters,
//   and only the readdatavalid strobe is routed to the requester that issued
//   the read.
//
//   Configuration macro:
//     ONCHIP_ARB_FIXED_PRIO_EN  defined   -> m0 always wins when requesting.
//                               undefined -> round-robin with a MAX_HOLD
//                                            burst allowance (default).
//
//   Reset is synchronous and active-high.
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4,            // legal range 1..15
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } req_id_e;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_SAT = 4'hF;

  // Registered arbitration and read-tracking state.
  req_id_e    owner, owner_d;
  req_id_e    last,  last_d;
  logic [3:0] hold_cnt, hold_cnt_d;
  logic       rd_pend, rd_pend_d;
  req_id_e    rd_id, rd_id_d;

  // Combinational grant.
  logic       grant_vld;
  req_id_e    grant_id;

  // Request vector indexed by requester id.
  logic [1:0] req;
  logic       sel_read;
  logic       sel_write;

  assign req[ID_M0] = m0_read | m0_write;
  assign req[ID_M1] = m1_read | m1_write;

  // Pick this cycle's winner; nothing is granted while reset is held.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    grant_vld = 1'b0;
    grant_id  = ID_M0;
    if (!reset) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      if (req[ID_M0]) begin
        grant_vld = 1'b1;
        grant_id  = ID_M0;
      end else if (req[ID_M1]) begin
        grant_vld = 1'b1;
        grant_id  = ID_M1;
      end
`else
      if (req[owner] && (hold_cnt < HOLD_LIM)) begin
        grant_vld = 1'b1;
        grant_id  = owner;
      end else if (req[~last]) begin
        grant_vld = 1'b1;
        grant_id  = req_id_e'(~last);
      end else if (req[last]) begin
        grant_vld = 1'b1;
        grant_id  = last;
      end
`endif
    end
  end

  assign sel_read  = (grant_id == ID_M1) ? m1_read  : m0_read;
  assign sel_write = (grant_id == ID_M1) ? m1_write : m0_write;

  // Compute next arbitration state and the read-pending marker for this beat.
  always_comb begin
    owner_d    = owner;
    last_d     = last;
    hold_cnt_d = hold_cnt;
    rd_pend_d  = 1'b0;
    rd_id_d    = rd_id;
    if (grant_vld) begin
      owner_d = grant_id;
      last_d  = grant_id;
      // The counter saturates so a lone requester streaming for a long time
      // cannot wrap back below MAX_HOLD and starve a late-arriving peer.
      if (grant_id == owner)
        hold_cnt_d = (hold_cnt == HOLD_SAT) ? HOLD_SAT : hold_cnt + 4'd1;
      else
        hold_cnt_d = 4'd1;
      // A beat with both read and write set is a write; no data comes back.
      rd_pend_d = sel_read & ~sel_write;
      rd_id_d   = grant_id;
    end else begin
      hold_cnt_d = 4'd0;
    end
  end

  // State register with synchronous reset; m0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      owner    <= ID_M0;
      last     <= ID_M1;
      hold_cnt <= 4'd0;
      rd_pend  <= 1'b0;
      rd_id    <= ID_M0;
    end else begin
      owner    <= owner_d;
      last     <= last_d;
      hold_cnt <= hold_cnt_d;
      rd_pend  <= rd_pend_d;
      rd_id    <= rd_id_d;
    end
  end

  // Steer the winner onto the RAM pins and answer both requesters.
  always_comb begin
    mem_address    = (grant_id == ID_M1) ? m1_address    : m0_address;
    mem_byteenable = (grant_id == ID_M1) ? m1_byteenable : m0_byteenable;
    mem_writedata  = (grant_id == ID_M1) ? m1_writedata  : m0_writedata;
    mem_chipselect = grant_vld;
    mem_write      = grant_vld & sel_write;
    mem_clken      = 1'b1;

    m0_waitrequest = ~(grant_vld && (grant_id == ID_M0));
    m1_waitrequest = ~(grant_vld && (grant_id == ID_M1));

    // A reset arriving the cycle after a read beat swallows its valid strobe.
    m0_readdatavalid = rd_pend & ~reset & (rd_id == ID_M0);
    m1_readdatavalid = rd_pend & ~reset & (rd_id == ID_M1);
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//   Directed bench for onchip_mem_arbiter. A small RAM model answers reads one
//   cycle after the beat. Inputs change on the falling edge; outputs are
//   sampled 1 ns later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk;
  logic              reset;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  int checks   = 0;
  int failures = 0;

  onchip_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM model, 256 words deep: byte-lane writes, 1-cycle reads.
  logic [DATA_W-1:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    mem_readdata = '0;
  end
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_m0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, '0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, '0);
  endtask

  int exp_id;
  int prev_id;

  initial begin
    // ---- Reset held 3 cycles with both requesters reading --------------
    reset = 1'b1;
    drive_m0(1'b1, 1'b0, 17'h00010, '0, 4'hF);
    drive_m1(1'b1, 1'b0, 17'h00020, '0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_wait0", m0_waitrequest, 1);
      check("rst_wait1", m1_waitrequest, 1);
      check("rst_cs",    mem_chipselect, 0);
      check("rst_wr",    mem_write, 0);
      check("rst_rdv0",  m0_readdatavalid, 0);
      check("rst_rdv1",  m1_readdatavalid, 0);
    end

    // ---- Idle after reset: nothing granted -----------------------------
    @(negedge clk);
    reset = 1'b0;
    idle_all();
    #1;
    check("idle_cs",    mem_chipselect, 0);
    check("idle_wait0", m0_waitrequest, 1);
    check("idle_wait1", m1_waitrequest, 1);
    check("clken",      mem_clken, 1);

    // ---- m0 writes 0xDEADBEEF to 0x10, then reads it back --------------
    @(negedge clk);
    drive_m0(1'b0, 1'b1, 17'h00010, 32'hDEADBEEF, 4'hF);
    #1;
    check("wr_wait0", m0_waitrequest, 0);
    check("wr_cs",    mem_chipselect, 1);
    check("wr_we",    mem_write, 1);
    check("wr_addr",  32'(mem_address), 32'h10);
    check("wr_data",  mem_writedata, 32'hDEADBEEF);

    @(negedge clk);
    drive_m0(1'b1, 1'b0, 17'h00010, '0, 4'hF);
    #1;
    check("rd_wait0", m0_waitrequest, 0);
    check("rd_we",    mem_write, 0);
    check("rd_rdv0_early", m0_readdatavalid, 0);

    @(negedge clk);
    idle_all();
    #1;
    check("rd_rdv0", m0_readdatavalid, 1);
    check("rd_rdv1", m1_readdatavalid, 0);
    check("rd_data", m0_readdata, 32'hDEADBEEF);

    // ---- Byte write by m1 over zeroed word, read back via m0 -----------
    @(negedge clk);
    drive_m0(1'b0, 1'b1, 17'h00020, 32'h0, 4'hF);
    @(negedge clk);
    drive_m0(1'b0, 1'b0, '0, '0, '0);
    drive_m1(1'b0, 1'b1, 17'h00020, 32'h11223344, 4'b0100);
    #1;
    check("bw_wait1", m1_waitrequest, 0);
    check("bw_be",    32'(mem_byteenable), 32'h4);
    @(negedge clk);
    drive_m1(1'b0, 1'b0, '0, '0, '0);
    drive_m0(1'b1, 1'b0, 17'h00020, '0, 4'hF);
    @(negedge clk);
    idle_all();
    #1;
    check("bw_rdv0", m0_readdatavalid, 1);
    check("bw_data", m0_readdata, 32'h00220000);

    // ---- Contention: both read continuously for 16 cycles --------------
    // Round-robin: m0 x4, m1 x4, m0 x4, m1 x4. Fixed priority: m0 always.
    prev_id = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_m0(1'b1, 1'b0, 17'h00010, '0, 4'hF);
      drive_m1(1'b1, 1'b0, 17'h00020, '0, 4'hF);
      #1;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = ((i / 4) % 2 == 0) ? 0 : 1;
`endif
      check("cont_wait0", m0_waitrequest, (exp_id == 0) ? 0 : 1);
      check("cont_wait1", m1_waitrequest, (exp_id == 1) ? 0 : 1);
      if (prev_id >= 0) begin
        check("cont_rdv0", m0_readdatavalid, (prev_id == 0) ? 1 : 0);
        check("cont_rdv1", m1_readdatavalid, (prev_id == 1) ? 1 : 0);
        check("cont_data", m0_readdata, (prev_id == 0) ? 32'hDEADBEEF : 32'h00220000);
      end
      prev_id = exp_id;
    end
    @(negedge clk);
    idle_all();
    #1;
    check("cont_last_rdv0", m0_readdatavalid, (prev_id == 0) ? 1 : 0);
    check("cont_last_rdv1", m1_readdatavalid, (prev_id == 1) ? 1 : 0);

    // ---- Mid-read reset: m1 read at T, reset at T+1 ---------------------
    @(negedge clk);
    drive_m1(1'b1, 1'b0, 17'h00010, '0, 4'hF);
    #1;
    check("mrr_wait1", m1_waitrequest, 0);
    @(negedge clk);
    reset = 1'b1;
    idle_all();
    #1;
    check("mrr_rdv1", m1_readdatavalid, 0);
    check("mrr_rdv0", m0_readdatavalid, 0);
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 17'h00010, '0, 4'hF);
    drive_m1(1'b1, 1'b0, 17'h00020, '0, 4'hF);
    #1;
    check("mrr_hold_rdv1", m1_readdatavalid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("tie_wait0", m0_waitrequest, 0);
    check("tie_wait1", m1_waitrequest, 1);
    @(negedge clk);
    idle_all();
    #1;
    check("tie_rdv0", m0_readdatavalid, 1);
    check("tie_data", m0_readdata, 32'hDEADBEEF);

    // ---- Write then read same address on consecutive cycles (m1) --------
    @(negedge clk);
    drive_m1(1'b0, 1'b1, 17'h00030, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drive_m1(1'b1, 1'b0, 17'h00030, '0, 4'hF);
    #1;
    check("wtr_wait1", m1_waitrequest, 0);
    @(negedge clk);
    idle_all();
    #1;
    check("wtr_rdv1", m1_readdatavalid, 1);
    check("wtr_data", m1_readdata, 32'hCAFEF00D);

    // ---- Read and write both set: treated as a write, no valid ----------
    @(negedge clk);
    drive_m0(1'b1, 1'b1, 17'h00040, 32'h5A5A5A5A, 4'hF);
    #1;
    check("rw_we",    mem_write, 1);
    check("rw_wait0", m0_waitrequest, 0);
    @(negedge clk);
    drive_m0(1'b1, 1'b0, 17'h00040, '0, 4'hF);
    #1;
    check("rw_rdv0", m0_readdatavalid, 0);
    @(negedge clk);
    idle_all();
    #1;
    check("rw_back_rdv0", m0_readdatavalid, 1);
    check("rw_back_data", m0_readdata, 32'h5A5A5A5A);

    // ---- Lone m0 streams past MAX_HOLD, then m1 joins --------------------
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_m0(1'b1, 1'b0, 17'h00010, '0, 4'hF);
      #1;
      check("solo_wait0", m0_waitrequest, 0);
    end
    @(negedge clk);
    drive_m1(1'b1, 1'b0, 17'h00020, '0, 4'hF);
    #1;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    check("join_wait0", m0_waitrequest, 0);
    check("join_wait1", m1_waitrequest, 1);
`else
    check("join_wait0", m0_waitrequest, 1);
    check("join_wait1", m1_waitrequest, 0);
`endif
    @(negedge clk);
    idle_all();
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
